stopwatch_ctrl: RTL

Run-control sequencer for the stopwatch counter chain (centisecond→second→minute).
- Debounces two raw push-buttons and runs the start/stop/lap/reset state machine.
- Drives the chain's pause and clear inputs, selects live or frozen display values, and stores up to LAP_DEPTH lap times for readback.
- Sits between the key pins, the counter chain and the display driver, in the 100 Hz domain.

---
 rtl/stopwatch_pkg.sv | 22 ++
 rtl/key_debounce.sv | 53 +++++
 rtl/stopwatch_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and widths for the stopwatch run-control block.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    LAP  = 2'd3
  } sw_state_e;

  localparam int unsigned TIME_W = 19;
  localparam int unsigned CS_W   = 7;
  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MIN_W  = 6;

  localparam int unsigned LAP_DEPTH_DEF = 4;
  localparam int unsigned LAP_AW        = $clog2(LAP_DEPTH_DEF);

  // Wide enough for the largest supported debounce count (15).
  localparam int unsigned DBNC_W = 4;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer, consecutive-sample debouncer and press pulse for one
// active-low key.
module key_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam logic [DBNC_W-1:0] LAST = DBNC_W'(DEBOUNCE_CNT - 1);

  logic              sync1_q, sync2_q;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic [DBNC_W-1:0] cnt_q, cnt_d;

  // Any sample agreeing with the accepted level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + DBNC_W'(1);
      end
    end
    press_d = level_q & ~level_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control: key conditioning, start/stop/lap/reset FSM,
// display hold mux and lap buffer.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter  int unsigned DEBOUNCE_CNT = 2,
  parameter  int unsigned LAP_DEPTH    = LAP_DEPTH_DEF,
  localparam int unsigned LAP_IW       = $clog2(LAP_DEPTH)
) (
  input  logic              clk_100Hz,
  input  logic              rst_n,
  input  logic              key_ss,
  input  logic              key_rl,
  input  logic [6:0]        centisecond,
  input  logic [5:0]        second,
  input  logic [5:0]        minute,
  input  logic [LAP_IW-1:0] lap_sel,
  output logic              pause,
  output logic              cnt_clr,
  output logic [6:0]        disp_cs,
  output logic [5:0]        disp_sec,
  output logic [5:0]        disp_min,
  output logic [LAP_IW:0]   lap_cnt,
  output logic              lap_full,
  output logic [18:0]       lap_rd,
  output logic [1:0]        state
);

  localparam logic [LAP_IW:0] FULL_CNT = (LAP_IW+1)'(LAP_DEPTH);

  logic ss_p, rl_p, ss_go, rl_go;

  key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_key_ss (
    .clk   (clk_100Hz),
    .rst_n (rst_n),
    .key_n (key_ss),
    .press (ss_p)
  );

  key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_key_rl (
    .clk   (clk_100Hz),
    .rst_n (rst_n),
    .key_n (key_rl),
    .press (rl_p)
  );

  // Start/stop has priority when both presses land in the same cycle.
  assign ss_go = ss_p;
  assign rl_go = rl_p & ~ss_p;

  sw_state_e         state_q, state_d;
  logic              pause_q, pause_d;
  logic              cnt_clr_q, cnt_clr_d;
  logic [TIME_W-1:0] live;
  logic [TIME_W-1:0] hold_q, hold_d;
  logic [TIME_W-1:0] disp_q, disp_d;
  logic [TIME_W-1:0] lap_q [LAP_DEPTH];
  logic [TIME_W-1:0] lap_d [LAP_DEPTH];
  logic [LAP_IW:0]   lap_cnt_q, lap_cnt_d;
  logic              capture, clear, full;

  assign live = {minute, second, centisecond};
  assign full = (lap_cnt_q == FULL_CNT);

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_go) state_d = RUN;
      end
      RUN: begin
        if (ss_go) begin
          state_d = STOP;
        end else if (rl_go) begin
          state_d = LAP;
          capture = 1'b1;
        end
      end
      LAP: begin
        if (ss_go)      state_d = STOP;
        else if (rl_go) state_d = RUN;
      end
      STOP: begin
        if (ss_go) begin
          state_d = RUN;
        end else if (rl_go) begin
          state_d = IDLE;
          clear   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pause_d   = (state_d == IDLE) || (state_d == STOP);
    cnt_clr_d = clear;
    hold_d    = capture ? live : hold_q;
    disp_d    = (state_q == LAP) ? hold_q : live;
    lap_d     = lap_q;
    lap_cnt_d = lap_cnt_q;
    if (clear) begin
      for (int unsigned i = 0; i < LAP_DEPTH; i++) lap_d[i] = '0;
      lap_cnt_d = '0;
    end else if (capture && !full) begin
      lap_d[lap_cnt_q[LAP_IW-1:0]] = live;
      lap_cnt_d = lap_cnt_q + (LAP_IW+1)'(1);
    end
  end

  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pause_q   <= 1'b1;
      cnt_clr_q <= 1'b0;
      hold_q    <= '0;
      disp_q    <= '0;
      lap_cnt_q <= '0;
      for (int unsigned i = 0; i < LAP_DEPTH; i++) lap_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pause_q   <= pause_d;
      cnt_clr_q <= cnt_clr_d;
      hold_q    <= hold_d;
      disp_q    <= disp_d;
      lap_cnt_q <= lap_cnt_d;
      lap_q     <= lap_d;
    end
  end

  always_comb begin
    lap_rd = '0;
    if ({1'b0, lap_sel} < lap_cnt_q) lap_rd = lap_q[lap_sel];
  end

  assign pause    = pause_q;
  assign cnt_clr  = cnt_clr_q;
  assign disp_cs  = disp_q[CS_W-1:0];
  assign disp_sec = disp_q[CS_W +: SEC_W];
  assign disp_min = disp_q[CS_W+SEC_W +: MIN_W];
  assign lap_cnt  = lap_cnt_q;
  assign lap_full = full;
  assign state    = state_q;

endmodule
